// File: rtl/sseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display stage.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);

  typedef logic [7:0] sseg_t;

  localparam sseg_t SSEG_BLANK = 8'hFF;

  // Inputs frozen for one refresh frame so digits never mix old and new counts
  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic [3:0] dp;
    logic       blank_lz;
  } snap_t;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment decoder, segments {g,f,e,d,c,b,a}.
module hex_to_sseg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/sseg_count_display.sv
// Renders two 8-bit edge counts as four hex digits on a time-multiplexed,
// active-low seven-segment display with per-frame input snapshots.
module sseg_count_display
  import sseg_pkg::*;
#(
  parameter int N_REFRESH = 18
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_hex_hi,
  input  logic [7:0]            i_hex_lo,
  input  logic [3:0]            i_dp,
  input  logic                  i_blank_lz,
  output logic [NUM_DIGITS-1:0] o_an,
  output sseg_t                 o_sseg,
  output logic                  o_frame_tick
);

  logic [N_REFRESH-1:0] r_refresh;
  snap_t                r_snap;
  logic [DIGIT_W-1:0]   digit;
  logic [3:0]           nibble;
  logic [6:0]           seg_dec;
  logic                 blank;
  logic                 frame_end;
  logic                 frame_start;

  assign digit       = r_refresh[N_REFRESH-1 -: DIGIT_W];
  assign frame_end   = &r_refresh;
  assign frame_start = (r_refresh == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_refresh <= '0;
      r_snap    <= '0;
    end else begin
      r_refresh <= r_refresh + N_REFRESH'(1);
      if (frame_end)
        r_snap <= {i_hex_hi, i_hex_lo, i_dp, i_blank_lz};
    end
  end

  always_comb begin
    nibble = 4'h0;
    case (digit)
      2'd3: nibble = r_snap.hi[7:4];
      2'd2: nibble = r_snap.hi[3:0];
      2'd1: nibble = r_snap.lo[7:4];
      2'd0: nibble = r_snap.lo[3:0];
      default: nibble = 4'h0;
    endcase
  end

  hex_to_sseg u_hex_to_sseg (
    .i_hex (nibble),
    .o_seg (seg_dec)
  );

  // Only the upper nibble of each byte (odd digits) may be blanked, so 0 shows as " 0"
  assign blank = r_snap.blank_lz && digit[0] && (nibble == 4'h0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an         <= '1;
      o_sseg       <= SSEG_BLANK;
      o_frame_tick <= 1'b0;
    end else begin
      o_an         <= ~(NUM_DIGITS'(1) << digit);
      o_sseg       <= {~r_snap.dp[digit], (blank ? 7'h7F : seg_dec)};
      o_frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_sseg_count_display.sv
// Scoreboard bench for sseg_count_display with a 16-cycle frame (N_REFRESH=4).
module tb_sseg_count_display;

  localparam int N_REFRESH = 4;
  localparam int FRAME     = 1 << N_REFRESH;

  logic       clk;
  logic       rst;
  logic [7:0] hex_hi;
  logic [7:0] hex_lo;
  logic [3:0] dp;
  logic       blank_lz;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  typedef struct {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int         m_cnt;
  logic [7:0] s_hi;
  logic [7:0] s_lo;
  logic [3:0] s_dp;
  logic       s_lz;

  int checks = 0;
  int errors = 0;

  sseg_count_display #(.N_REFRESH(N_REFRESH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_hex_hi     (hex_hi),
    .i_hex_lo     (hex_lo),
    .i_dp         (dp),
    .i_blank_lz   (blank_lz),
    .o_an         (an),
    .o_sseg       (sseg),
    .o_frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Predict the outputs after the coming edge, advance the model, then compare
  task automatic step();
    exp_t       e;
    int         d;
    logic [3:0] nib;
    logic [6:0] seg;
    if (rst) begin
      e = '{an: 4'hF, sseg: 8'hFF, tick: 1'b0};
      m_cnt = 0;
      s_hi = 8'h00; s_lo = 8'h00; s_dp = 4'h0; s_lz = 1'b0;
    end else begin
      d = m_cnt / 4;
      case (d)
        3: nib = s_hi[7:4];
        2: nib = s_hi[3:0];
        1: nib = s_lo[7:4];
        default: nib = s_lo[3:0];
      endcase
      seg = (s_lz && (d == 1 || d == 3) && nib == 4'h0) ? 7'h7F : seg_tab[nib];
      e.an   = ~(4'b0001 << d);
      e.sseg = {~s_dp[d], seg};
      e.tick = (m_cnt == 0);
      if (m_cnt == FRAME - 1) begin
        s_hi = hex_hi; s_lo = hex_lo; s_dp = dp; s_lz = blank_lz;
      end
      m_cnt = (m_cnt + 1) % FRAME;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check_output("an", {4'h0, an}, {4'h0, e.an});
    check_output("sseg", sseg, e.sseg);
    check_output("tick", {7'h0, frame_tick}, {7'h0, e.tick});
  endtask

  task automatic run_to_phase(input int p);
    do step(); while (m_cnt != p);
  endtask

  task automatic apply_stimulus(input logic [7:0] hi, input logic [7:0] lo,
                                input logic [3:0] dpv, input logic lz);
    hex_hi = hi; hex_lo = lo; dp = dpv; blank_lz = lz;
  endtask

  logic [7:0] frame_exp [4];

  initial begin
    rst = 1'b1;
    m_cnt = 0;
    apply_stimulus(8'h00, 8'h00, 4'h0, 1'b0);
    @(negedge clk);

    $display("[TB] reset");
    repeat (3) step();
    check_output("rst_an", {4'h0, an}, 8'h0F);
    check_output("rst_sseg", sseg, 8'hFF);
    rst = 1'b0;
    step();
    check_output("first_an", {4'h0, an}, 8'h0E);
    check_output("first_sseg", sseg, 8'hC0);
    check_output("first_tick", {7'h0, frame_tick}, 8'h01);

    $display("[TB] basic display");
    apply_stimulus(8'hA5, 8'h3C, 4'h0, 1'b0);
    run_to_phase(0);
    frame_exp = '{8'hC6, 8'hB0, 8'h92, 8'h88};
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (i % 4 == 0) begin
        check_output("basic_sseg", sseg, frame_exp[i/4]);
        check_output("basic_an", {4'h0, an}, {4'h0, ~(4'b0001 << (i/4))});
      end
    end

    $display("[TB] blanking and dp");
    apply_stimulus(8'h07, 8'h00, 4'b0100, 1'b1);
    run_to_phase(0);
    frame_exp = '{8'hC0, 8'hFF, 8'h78, 8'hFF};
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (i % 4 == 0) check_output("lz_sseg", sseg, frame_exp[i/4]);
    end

    $display("[TB] mid-frame change");
    apply_stimulus(8'h00, 8'h12, 4'h0, 1'b0);
    run_to_phase(0);
    run_to_phase(6);
    hex_lo = 8'h34;
    step();
    step();
    check_output("torn_old", sseg, 8'hF9);
    run_to_phase(0);
    step();
    check_output("torn_new", sseg, 8'h99);

    $display("[TB] snapshot edge");
    run_to_phase(FRAME - 1);
    hex_hi = 8'h5A;
    step();
    run_to_phase(8);
    step();
    check_output("edge_capture", sseg, 8'h88);
    run_to_phase(FRAME - 1);
    step();
    hex_hi = 8'hC3;
    run_to_phase(8);
    step();
    check_output("edge_defer", sseg, 8'h88);
    run_to_phase(8);
    step();
    check_output("edge_late", sseg, 8'hB0);

    $display("[TB] reset mid-frame");
    run_to_phase(9);
    rst = 1'b1;
    step();
    check_output("mid_rst_an", {4'h0, an}, 8'h0F);
    check_output("mid_rst_sseg", sseg, 8'hFF);
    rst = 1'b0;
    step();
    check_output("restart_sseg", sseg, 8'hC0);
    check_output("restart_tick", {7'h0, frame_tick}, 8'h01);
    repeat (FRAME - 1) step();
    step();
    check_output("next_tick", {7'h0, frame_tick}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
